// File: rtl/pattern_playback_ctrl.sv
// Pattern ROM sequencer: paces the ROM address at a selectable frame rate and
// registers each fetched word after the ROM latency, flagging it with a strobe.
module pattern_playback_ctrl #(
  parameter int unsigned CLOCK_FREQUENCY = 200000000,
  parameter int unsigned REFRESH_RATE    = 10,
  parameter int unsigned ROM_DEPTH       = 36,
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ROM_LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_play,
  input  logic                  cmd_pause,
  input  logic                  cmd_step,
  input  logic                  cmd_restart,
  input  logic [1:0]            mode,
  input  logic [1:0]            rate_sel,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  frame_strobe,
  output logic [1:0]            state,
  output logic                  done
);

  localparam int unsigned BASE_PERIOD = CLOCK_FREQUENCY / REFRESH_RATE;
  localparam int unsigned LW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ROM_DEPTH - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(ROM_LATENCY - 1);

  generate
    if (BASE_PERIOD <= ROM_LATENCY || ROM_DEPTH < 2 || (2 ** ADDR_WIDTH) < ROM_DEPTH) begin : g_bad_params
      $error("pattern_playback_ctrl: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_DONE = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  dir_up_q, dir_up_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [1:0]            rate_q, rate_d;
  logic [1:0]            mode_q, mode_d;
  logic                  pend_q, pend_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  strobe_q, strobe_d;

  logic [ADDR_WIDTH-1:0] adv_addr;
  logic                  adv_dir_up, adv_moves;
  logic [31:0]           period;
  logic                  capture, fetch, do_adv, run_step;

  // Next address/direction for one advance, using the live mode so a mode
  // change lands at the next advance; endpoints recompute the direction.
  always_comb begin
    adv_addr   = addr_q;
    adv_dir_up = 1'b1;
    adv_moves  = 1'b1;
    case (mode)
      2'd1: begin
        adv_dir_up = dir_up_q;
        if (addr_q == LAST)      adv_dir_up = 1'b0;
        else if (addr_q == '0)   adv_dir_up = 1'b1;
        adv_addr = adv_dir_up ? addr_q + ADDR_WIDTH'(1) : addr_q - ADDR_WIDTH'(1);
      end
      2'd2: begin
        if (addr_q == LAST) adv_moves = 1'b0;
        else                adv_addr  = addr_q + ADDR_WIDTH'(1);
      end
      default: adv_addr = (addr_q == LAST) ? '0 : addr_q + ADDR_WIDTH'(1);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    rate_d   = rate_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    lat_d    = lat_q;
    dout_d   = dout_q;
    strobe_d = 1'b0;
    fetch    = 1'b0;
    do_adv   = 1'b0;
    run_step = 1'b0;
    period   = 32'(BASE_PERIOD) << rate_q;
    capture  = pend_q && (lat_q == LAT_LAST);

    if (cmd_restart) begin
      addr_d   = '0;
      dir_up_d = 1'b1;
      cnt_d    = '0;
      fetch    = 1'b1;
      if (state_q == S_DONE) state_d = S_IDLE;
    end else if (cmd_pause) begin
      if (state_q == S_RUN) state_d = S_PAUSED;
    end else if (cmd_play) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          cnt_d   = '0;
          rate_d  = rate_sel;
          mode_d  = mode;
        end
        S_PAUSED: state_d = S_RUN;
        S_DONE: begin
          state_d  = S_RUN;
          addr_d   = '0;
          dir_up_d = 1'b1;
          cnt_d    = '0;
          rate_d   = rate_sel;
          mode_d   = mode;
          fetch    = 1'b1;
        end
        default: run_step = 1'b1;
      endcase
    end else begin
      if (cmd_step && !pend_q && (state_q == S_IDLE || state_q == S_PAUSED)) do_adv = 1'b1;
      if (state_q == S_RUN) run_step = 1'b1;
    end

    if (run_step) begin
      if (cnt_q == period - 32'd1) begin
        cnt_d  = '0;
        do_adv = 1'b1;
        rate_d = rate_sel;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      if (capture && mode_q == 2'd2 && addr_q == LAST) state_d = S_DONE;
    end

    if (do_adv) begin
      mode_d   = mode;
      dir_up_d = adv_dir_up;
      if (adv_moves) begin
        addr_d = adv_addr;
        fetch  = 1'b1;
      end else if (state_q == S_RUN && !pend_q) begin
        // Reached the last frame by stepping, then resumed: nothing left to play.
        state_d = S_DONE;
      end
    end

    // A new fetch supersedes any one in flight; only the newest address lands.
    if (fetch) begin
      pend_d = 1'b1;
      lat_d  = '0;
    end else if (pend_q) begin
      if (capture) begin
        pend_d   = 1'b0;
        dout_d   = rom_dout;
        strobe_d = 1'b1;
      end else begin
        lat_d = lat_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      dir_up_q <= 1'b1;
      cnt_q    <= '0;
      rate_q   <= '0;
      mode_q   <= '0;
      pend_q   <= 1'b1;
      lat_q    <= '0;
      dout_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dir_up_q <= dir_up_d;
      cnt_q    <= cnt_d;
      rate_q   <= rate_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      lat_q    <= lat_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
    end
  end

  assign rom_addr     = addr_q;
  assign dout         = dout_q;
  assign frame_strobe = strobe_q;
  assign state        = state_q;
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_pattern_playback_ctrl.sv
// Bench for pattern_playback_ctrl: small config, ROM word = 0xA0 + addr.
// Expected frame words are queued as stimulus is applied and popped on each strobe.
module tb_pattern_playback_ctrl;
  localparam int AW = 2;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_play = 1'b0, cmd_pause = 1'b0, cmd_step = 1'b0, cmd_restart = 1'b0;
  logic [1:0]    mode = 2'd0, rate_sel = 2'd0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout, dout;
  logic          frame_strobe, done;
  logic [1:0]    state;

  int            checks = 0, failures = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  // One registered stage: data for an address set at edge E is seen at E+2.
  always @(posedge clk) rom_dout <= 64'hA0 + 64'(rom_addr);

  pattern_playback_ctrl #(
    .CLOCK_FREQUENCY(40), .REFRESH_RATE(10), .ROM_DEPTH(4),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_step(cmd_step), .cmd_restart(cmd_restart),
    .mode(mode), .rate_sel(rate_sel),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .dout(dout), .frame_strobe(frame_strobe), .state(state), .done(done)
  );

  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    if (resetn && frame_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: dout=%h with no frame expected", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL frame_data: got %h want %h", dout, e);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    {cmd_play, cmd_pause, cmd_step, cmd_restart} = '0;
    tick();
    exp_q.delete();
    tick();
    resetn = 1'b1;
    exp_q.push_back(64'hA0);
    repeat (2) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) tick();
    checks++; if (rom_addr !== '0)     begin failures++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    checks++; if (dout !== '0)         begin failures++; $display("FAIL reset_dout: got %h want 0", dout); end
    checks++; if (frame_strobe !== 0)  begin failures++; $display("FAIL reset_strobe: got %b want 0", frame_strobe); end
    checks++; if (state !== 2'd0)      begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    resetn = 1'b1;
    exp_q.push_back(64'hA0);
    tick();
    checks++; if (frame_strobe !== 0)  begin failures++; $display("FAIL reset_early_strobe: got %b want 0", frame_strobe); end
    tick();
    checks++; if (frame_strobe !== 1)  begin failures++; $display("FAIL reset_fetch_strobe: got %b want 1", frame_strobe); end
    checks++; if (dout !== 64'hA0)     begin failures++; $display("FAIL reset_fetch_dout: got %h want a0", dout); end
    repeat (20) tick();
    checks++; if (state !== 2'd0 || rom_addr !== '0) begin
      failures++; $display("FAIL idle_hold: state=%0d addr=%0d want 0/0", state, rom_addr);
    end
  endtask

  task automatic test_loop();
    int seq[5] = '{1, 2, 3, 0, 1};
    logic [AW-1:0] prev = '0;
    do_reset();
    mode = 2'd0; rate_sel = 2'd0;
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    foreach (seq[i]) begin
      repeat (3) tick();
      checks++; if (rom_addr !== prev) begin failures++; $display("FAIL loop_hold[%0d]: got %0d want %0d", i, rom_addr, prev); end
      exp_q.push_back(64'hA0 + 64'(seq[i]));
      tick();
      checks++; if (rom_addr !== AW'(seq[i])) begin failures++; $display("FAIL loop_addr[%0d]: got %0d want %0d", i, rom_addr, seq[i]); end
      prev = AW'(seq[i]);
    end
    repeat (2) tick();
  endtask

  task automatic test_pingpong();
    int seq[7] = '{1, 2, 3, 2, 1, 0, 1};
    logic [AW-1:0] prev = '0;
    do_reset();
    mode = 2'd1; rate_sel = 2'd1;
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    foreach (seq[i]) begin
      repeat (7) tick();
      checks++; if (rom_addr !== prev) begin failures++; $display("FAIL pp_hold[%0d]: got %0d want %0d", i, rom_addr, prev); end
      exp_q.push_back(64'hA0 + 64'(seq[i]));
      tick();
      checks++; if (rom_addr !== AW'(seq[i])) begin failures++; $display("FAIL pp_addr[%0d]: got %0d want %0d", i, rom_addr, seq[i]); end
      prev = AW'(seq[i]);
    end
    repeat (2) tick();
  endtask

  task automatic test_oneshot();
    do_reset();
    mode = 2'd2; rate_sel = 2'd0;
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      repeat (3) tick();
      exp_q.push_back(64'hA0 + 64'(a));
      tick();
      checks++; if (rom_addr !== AW'(a)) begin failures++; $display("FAIL os_addr[%0d]: got %0d want %0d", a, rom_addr, a); end
    end
    repeat (2) tick();
    checks++; if (state !== 2'd3 || done !== 1'b1) begin
      failures++; $display("FAIL os_done: state=%0d done=%b want 3/1", state, done);
    end
    repeat (12) tick();
    checks++; if (rom_addr !== AW'(3) || state !== 2'd3) begin
      failures++; $display("FAIL os_stuck: addr=%0d state=%0d want 3/3", rom_addr, state);
    end
    exp_q.push_back(64'hA0);
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    checks++; if (rom_addr !== '0 || state !== 2'd1 || done !== 1'b0) begin
      failures++; $display("FAIL os_replay: addr=%0d state=%0d done=%b want 0/1/0", rom_addr, state, done);
    end
    repeat (2) tick();
  endtask

  task automatic test_idle_step();
    do_reset();
    mode = 2'd2;
    for (int a = 1; a <= 3; a++) begin
      exp_q.push_back(64'hA0 + 64'(a));
      cmd_step = 1'b1; tick(); cmd_step = 1'b0;
      checks++; if (rom_addr !== AW'(a) || state !== 2'd0) begin
        failures++; $display("FAIL idle_step[%0d]: addr=%0d state=%0d want %0d/0", a, rom_addr, state, a);
      end
      repeat (2) tick();
    end
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    checks++; if (rom_addr !== AW'(3) || state !== 2'd0) begin
      failures++; $display("FAIL os_step_end: addr=%0d state=%0d want 3/0", rom_addr, state);
    end
    repeat (3) tick();
  endtask

  task automatic test_pause_step();
    do_reset();
    mode = 2'd0; rate_sel = 2'd0;
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    repeat (2) tick();
    cmd_pause = 1'b1; tick(); cmd_pause = 1'b0;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL pause_state: got %0d want 2", state); end
    repeat (10) tick();
    checks++; if (rom_addr !== '0 || state !== 2'd2) begin
      failures++; $display("FAIL pause_hold: addr=%0d state=%0d want 0/2", rom_addr, state);
    end
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    tick();
    checks++; if (rom_addr !== '0 || state !== 2'd1) begin
      failures++; $display("FAIL resume_early: addr=%0d state=%0d want 0/1", rom_addr, state);
    end
    exp_q.push_back(64'hA1);
    tick();
    checks++; if (rom_addr !== AW'(1)) begin failures++; $display("FAIL resume_adv: got %0d want 1", rom_addr); end
    repeat (2) tick();
    cmd_pause = 1'b1; tick(); cmd_pause = 1'b0;
    exp_q.push_back(64'hA2);
    cmd_step = 1'b1; tick();
    checks++; if (rom_addr !== AW'(2) || state !== 2'd2) begin
      failures++; $display("FAIL paused_step: addr=%0d state=%0d want 2/2", rom_addr, state);
    end
    tick(); cmd_step = 1'b0;
    checks++; if (rom_addr !== AW'(2)) begin failures++; $display("FAIL step_pending: got %0d want 2", rom_addr); end
    tick();
    exp_q.push_back(64'hA0);
    cmd_restart = 1'b1; cmd_play = 1'b1; tick(); cmd_restart = 1'b0; cmd_play = 1'b0;
    checks++; if (rom_addr !== '0 || state !== 2'd2) begin
      failures++; $display("FAIL restart_play: addr=%0d state=%0d want 0/2", rom_addr, state);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    mode = 2'd0; rate_sel = 2'd0;
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    repeat (3) tick();
    exp_q.push_back(64'hA1);
    tick();
    checks++; if (rom_addr !== AW'(1)) begin failures++; $display("FAIL mid_addr: got %0d want 1", rom_addr); end
    tick();
    resetn = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (rom_addr !== '0 || dout !== '0 || frame_strobe !== 1'b0 || state !== 2'd0 || done !== 1'b0) begin
      failures++; $display("FAIL mid_reset: addr=%0d dout=%h strobe=%b state=%0d done=%b want all 0",
                           rom_addr, dout, frame_strobe, state, done);
    end
    repeat (3) tick();
    resetn = 1'b1;
    exp_q.push_back(64'hA0);
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_loop();
    test_pingpong();
    test_oneshot();
    test_idle_step();
    test_pause_step();
    test_reset_midfetch();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL missing_frames: %0d expected frames never strobed, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
